// File: rtl/bus_stream_bridge.sv
// MMIO bridge between the OR-bus and a pair of byte streams (TX: bus->stream, RX: stream->bus).
// Reads return registered data one cycle after cs (zero otherwise); in_ready is always 1 and bytes arriving at a full FIFO are dropped.

module bsb_fifo #(
  parameter int AW = 4
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  logic [7:0]    wdata_i,
  output logic [7:0]    rdata_o,
  output logic [AW:0]   count_o,
  output logic          drop_o
);
  localparam int DEPTH = 1 << AW;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          full, do_pop, do_push;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  always_comb begin
    do_pop   = pop_i & (count_q != '0);
    do_push  = push_i & (~full | do_pop);
    drop_o   = push_i & full & ~do_pop & ~flush_i;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end
endmodule

module bus_stream_bridge #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        cs_i,
  input  logic        wren_i,
  input  logic [1:0]  reg_sel_i,
  input  logic [7:0]  di_i,
  output logic [31:0] do_o,
  output logic [7:0]  out_data_o,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  input  logic [7:0]  in_data_i,
  input  logic        in_valid_i,
  output logic        in_ready_o
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [DEPTH_LOG2:0] tx_count, rx_count;
  logic [7:0]          rx_head;
  logic                tx_drop, rx_drop;
  logic                wr_acc, rd_acc, tx_push, rx_pop, tx_flush, rx_flush, sts_wr;
  logic                tx_ovf_q, tx_ovf_d, rx_ovf_q, rx_ovf_d;
  logic [31:0]         do_q, do_d, status;

  assign wr_acc   = cs_i & wren_i;
  assign rd_acc   = cs_i & ~wren_i;
  assign tx_push  = wr_acc & (reg_sel_i == 2'd0);
  assign rx_pop   = rd_acc & (reg_sel_i == 2'd0);
  assign sts_wr   = wr_acc & (reg_sel_i == 2'd1);
  assign tx_flush = wr_acc & (reg_sel_i == 2'd2) & di_i[0];
  assign rx_flush = wr_acc & (reg_sel_i == 2'd2) & di_i[1];

  assign out_valid_o = (tx_count != '0);
  assign in_ready_o  = 1'b1;
  assign do_o        = do_q;

  bsb_fifo #(.AW(DEPTH_LOG2)) u_tx (
    .clk_i(clk_i), .reset_i(reset_i),
    .push_i(tx_push), .pop_i(out_ready_i), .flush_i(tx_flush),
    .wdata_i(di_i), .rdata_o(out_data_o), .count_o(tx_count), .drop_o(tx_drop)
  );

  bsb_fifo #(.AW(DEPTH_LOG2)) u_rx (
    .clk_i(clk_i), .reset_i(reset_i),
    .push_i(in_valid_i), .pop_i(rx_pop), .flush_i(rx_flush),
    .wdata_i(in_data_i), .rdata_o(rx_head), .count_o(rx_count), .drop_o(rx_drop)
  );

  // Snapshot of pre-edge state; counts zero-extend into their byte fields.
  assign status = {8'h00, 8'(tx_count), 8'(rx_count), 4'h0,
                   tx_ovf_q, rx_ovf_q,
                   (tx_count != (DEPTH_LOG2+1)'(DEPTH)), (rx_count != '0)};

  always_comb begin
    tx_ovf_d = tx_ovf_q | tx_drop;
    rx_ovf_d = rx_ovf_q | rx_drop;
    if (sts_wr && di_i[2]) rx_ovf_d = 1'b0;
    if (sts_wr && di_i[3]) tx_ovf_d = 1'b0;
    do_d = 32'h0;
    if (rd_acc) begin
      case (reg_sel_i)
        2'd0:    do_d = (rx_count != '0) ? {24'h0, rx_head} : 32'h0;
        2'd1:    do_d = status;
        default: do_d = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      tx_ovf_q <= 1'b0;
      rx_ovf_q <= 1'b0;
      do_q     <= 32'h0;
    end else begin
      tx_ovf_q <= tx_ovf_d;
      rx_ovf_q <= rx_ovf_d;
      do_q     <= do_d;
    end
  end
endmodule

// File: tb/tb_bus_stream_bridge.sv
// Bench for bus_stream_bridge: queue-based reference checked every cycle plus directed literal checks.
module tb_bus_stream_bridge;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cs = 1'b0, wren = 1'b0, out_ready = 1'b0, in_valid = 1'b0;
  logic [1:0]  reg_sel = 2'd0;
  logic [7:0]  di = 8'h00, in_data = 8'h00;
  logic [31:0] do_o;
  logic [7:0]  out_data;
  logic        out_valid, in_ready;

  int tests = 0;
  int fails = 0;

  bus_stream_bridge #(.DEPTH_LOG2(4)) dut (
    .clk_i(clk), .reset_i(reset), .cs_i(cs), .wren_i(wren), .reg_sel_i(reg_sel),
    .di_i(di), .do_o(do_o), .out_data_o(out_data), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(in_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain queues and flags following the register map.
  logic [7:0]  txq[$];
  logic [7:0]  rxq[$];
  logic        m_tx_ovf = 1'b0, m_rx_ovf = 1'b0, started = 1'b0;
  logic        set_tx, set_rx;
  logic [31:0] exp_do = 32'h0, m_status;

  always @(posedge clk) begin
    if (reset) begin
      txq.delete();
      rxq.delete();
      m_tx_ovf = 1'b0;
      m_rx_ovf = 1'b0;
      exp_do   = 32'h0;
      started  = 1'b1;
    end else begin
      m_status = {8'h00, 8'(txq.size()), 8'(rxq.size()), 4'h0, m_tx_ovf, m_rx_ovf,
                  txq.size() < DEPTH, rxq.size() != 0};
      exp_do = 32'h0;
      set_tx = 1'b0;
      set_rx = 1'b0;
      if (cs && !wren) begin
        if (reg_sel == 2'd0 && rxq.size() != 0) exp_do = {24'h0, rxq.pop_front()};
        else if (reg_sel == 2'd1) exp_do = m_status;
      end
      if (cs && wren && reg_sel == 2'd2 && di[1]) rxq.delete();
      else if (in_valid) begin
        if (rxq.size() < DEPTH) rxq.push_back(in_data);
        else set_rx = 1'b1;
      end
      if (cs && wren && reg_sel == 2'd2 && di[0]) txq.delete();
      else begin
        if (out_ready && txq.size() != 0) void'(txq.pop_front());
        if (cs && wren && reg_sel == 2'd0) begin
          if (txq.size() < DEPTH) txq.push_back(di);
          else set_tx = 1'b1;
        end
      end
      if (set_rx) m_rx_ovf = 1'b1;
      if (set_tx) m_tx_ovf = 1'b1;
      if (cs && wren && reg_sel == 2'd1) begin
        if (di[2]) m_rx_ovf = 1'b0;
        if (di[3]) m_tx_ovf = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("cyc_do", do_o, exp_do);
      check("cyc_out_valid", 32'(out_valid), 32'(txq.size() != 0));
      if (txq.size() != 0) check("cyc_out_data", 32'(out_data), 32'(txq[0]));
      check("cyc_in_ready", 32'(in_ready), 32'd1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] sel, input logic [7:0] d);
    cs = 1'b1; wren = 1'b1; reg_sel = sel; di = d;
    tick();
    cs = 1'b0; wren = 1'b0;
  endtask

  task automatic bus_read(input string name, input logic [1:0] sel, input logic [31:0] exp);
    cs = 1'b1; wren = 1'b0; reg_sel = sel;
    tick();
    cs = 1'b0;
    check(name, do_o, exp);
  endtask

  task automatic rx_byte(input logic [7:0] b);
    in_valid = 1'b1; in_data = b;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_do", do_o, 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // TX basic path
    bus_write(2'd0, 8'h41);
    bus_write(2'd0, 8'h42);
    check("tx_valid", 32'(out_valid), 32'd1);
    check("tx_head", 32'(out_data), 32'h41);
    bus_read("tx_status", 2'd1, 32'h0002_0002);
    out_ready = 1'b1;
    check("tx_first", 32'(out_data), 32'h41);
    tick();
    check("tx_second", 32'(out_data), 32'h42);
    tick();
    check("tx_drained", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // RX basic path, including pop of empty
    rx_byte(8'h10);
    rx_byte(8'h20);
    tick();
    check("rx_idle_do", do_o, 32'h0);
    bus_read("rx_read1", 2'd0, 32'h10);
    bus_read("rx_read2", 2'd0, 32'h20);
    bus_read("rx_read_empty", 2'd0, 32'h0);
    bus_read("ctrl_read", 2'd2, 32'h0);
    bus_read("reg3_read", 2'd3, 32'h0);

    // RX overflow and flag clear
    for (int i = 0; i < 17; i++) rx_byte(8'(8'h80 + i));
    bus_read("rx_full_status", 2'd1, 32'h0000_1007);
    bus_write(2'd1, 8'h04);
    bus_read("rx_ovf_cleared", 2'd1, 32'h0000_1003);
    for (int i = 0; i < 16; i++) bus_read("rx_drain", 2'd0, 32'(8'h80 + i));
    bus_read("rx_17th_lost", 2'd0, 32'h0);

    // TX full: simultaneous push and pop, then a real overflow
    for (int i = 0; i < 16; i++) bus_write(2'd0, 8'(8'h60 + i));
    out_ready = 1'b1;
    bus_write(2'd0, 8'h70);
    out_ready = 1'b0;
    check("tx_full_head", 32'(out_data), 32'h61);
    bus_read("tx_full_pushpop", 2'd1, 32'h0010_0000);
    bus_write(2'd0, 8'h71);
    bus_read("tx_ovf_set", 2'd1, 32'h0010_0008);
    bus_write(2'd1, 8'h08);
    bus_read("tx_ovf_cleared", 2'd1, 32'h0010_0000);

    // Flushes
    bus_write(2'd2, 8'h01);
    bus_write(2'd0, 8'hA1);
    bus_write(2'd0, 8'hA2);
    for (int i = 0; i < 3; i++) rx_byte(8'(8'hB1 + i));
    bus_read("pre_flush_status", 2'd1, 32'h0002_0303);
    bus_write(2'd2, 8'h03);
    bus_read("post_flush_status", 2'd1, 32'h0000_0002);
    check("post_flush_valid", 32'(out_valid), 32'd0);

    // Reset mid-traffic
    bus_write(2'd0, 8'hC1);
    for (int i = 0; i < 17; i++) rx_byte(8'(8'hD0 + i));
    bus_read("pre_reset_status", 2'd1, 32'h0001_1007);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_reset_valid", 32'(out_valid), 32'd0);
    check("mid_reset_do", do_o, 32'h0);
    bus_read("mid_reset_status", 2'd1, 32'h0000_0002);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/bus_stream_bridge.md
Name: bus_stream_bridge

Overview:
- Memory-mapped responder on the SoC OR-bus, selected from the MMIO window by the top-level address decode.
- Bridges CPU/debugger bus accesses to a pair of byte-stream ports, each with a FIFO:
  - TX FIFO: bus writes in, valid/ready stream out.
  - RX FIFO: valid/ready stream in, bus reads out.
- Read data follows the bus convention: valid one cycle after select, zero otherwise, so it can be ORed into mem_do.

Parameters:
DEPTH_LOG2, 4, log2 of each FIFO depth (16 entries); legal range 1..7.

Ports:
clk  in  1  system clock (clk_16M domain)
reset  in  1  synchronous, active-high reset
cs  in  1  bus select, one-cycle pulse per access
wren  in  1  1 = write, 0 = read (top level drives |mem_wren)
reg_sel  in  2  register index (adr[3:2])
di  in  8  write data (mem_di[7:0])
do  out  32  read data; registered; 0 when no read was issued last cycle
out_data  out  8  TX stream byte (head of TX FIFO)
out_valid  out  1  TX FIFO non-empty
out_ready  in  1  sink accepts out_data when out_valid & out_ready
in_data  in  8  RX stream byte
in_valid  in  1  source presents in_data
in_ready  out  1  constant 1; bytes arriving while RX full are dropped

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high.
  - Reset clears both FIFO pointers and counts, both sticky overflow flags, and do.
  - After reset: out_valid=0, do=0, in_ready=1.
  - Reset asserted mid-transfer discards all FIFO contents in the same edge.
- Register map (reg_sel):
  - 0 DATA:
    - Write pushes di into TX FIFO.
    - Read pops RX FIFO; do[7:0]=head byte, do[31:8]=0.
  - 1 STATUS (read):
    - bit0 rx_nonempty, bit1 tx_nonfull, bit2 rx_overflow, bit3 tx_overflow.
    - bits[15:8] rx_count, bits[23:16] tx_count; other bits 0.
    - Write: di[2]=1 clears rx_overflow, di[3]=1 clears tx_overflow.
  - 2 CTRL:
    - Write di[0]=1 flushes TX FIFO; di[1]=1 flushes RX FIFO. Both are self-clearing.
    - Read returns 0.
  - 3: reads 0; writes ignored.
- Read latency: exactly 1 cycle.
  - cs & ~wren at edge N: do holds the value at edge N+1.
  - Every other cycle do is 0.
  - A pop occurs only at the cs cycle, so one pop per access.
- FIFO implementation:
  - Circular buffer, DEPTH_LOG2-bit pointers that wrap modulo depth.
  - Count is DEPTH_LOG2+1 bits, zero-extended into its 8-bit status field.
- TX FIFO:
  - Push on cs & wren & reg_sel==0.
  - Pop on out_valid & out_ready.
  - out_data = buffer[rd_ptr], combinationally (first-word-fall-through); out_valid = (tx_count != 0).
  - Push while full: byte dropped, count unchanged, tx_overflow set.
  - Push and pop in the same cycle while full: both happen (pop frees the slot), count unchanged, no overflow.
- RX FIFO:
  - Push on in_valid.
  - Push while full: byte dropped, rx_overflow set.
  - Simultaneous push and pop while full: both happen, no overflow.
  - Pop of empty RX: do=0, pointers unchanged, no flag change.
- Status snapshot: STATUS reads report counts and flags before that cycle's updates (registered from pre-edge state).
- Precedence:
  - Flush beats a simultaneous stream push/pop on the same FIFO (result empty).
  - Flag clear by a STATUS write beats a simultaneous overflow set; the flag stays clear.

Test Plan:
- Reset then write DATA 0x41, 0x42 with out_ready=0 -> out_valid=1, out_data=0x41, STATUS reads 0x00020002; raise out_ready -> 0x41 then 0x42 delivered on consecutive cycles, then out_valid=0.
- in_valid one cycle each with 0x10, 0x20; read DATA twice -> do=0x10 one cycle after first cs, 0x20 after second; third read -> do=0; do=0 on every non-read cycle.
- 17 in_valid bytes with no reads (DEPTH_LOG2=4) -> STATUS bits2,0 set, rx_count=16; write STATUS di=0x04 -> bit2 clears, count stays 16; byte 17 is never read back.
- TX full (16 writes, out_ready=0); next cycle issue 17th write with out_ready=1 -> push and pop both happen, tx_count=16, tx_overflow=0.
- RX holding 3 bytes, tx holding 2; write CTRL di=0x03 -> next STATUS read 0x00000002 (tx_nonfull only), out_valid=0.
- Assert reset for one cycle while out_valid=1 and RX non-empty -> next cycle out_valid=0, do=0, STATUS=0x00000002, overflow flags cleared.
